// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Round-robin share of the memory_map port between two masters,
//            one transaction in flight, fixed read latency.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_write_data,
    input  logic              m0_write_enable,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_read_data,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_write_data,
    input  logic              m1_write_enable,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              busy,
    output logic [ADDR_W-1:0] memory__address,
    output logic [DATA_W-1:0] memory__write_data,
    output logic              memory__write_enable,
    input  logic [DATA_W-1:0] memory__read_data
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;
    localparam int         c_CNT_W = 3;
    localparam logic [c_CNT_W-1:0] c_LOAD =
        (READ_LATENCY > 0) ? c_CNT_W'(READ_LATENCY - 1) : '0;
    localparam logic c_ZERO_LAT = (READ_LATENCY == 0);

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [c_CNT_W-1:0] r_count;
    logic [ADDR_W-1:0]  r_addr;

    logic               w_any_req;
    logic               w_winner;
    logic               w_accept;
    logic               w_start_wait;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_wdata;
    logic               w_win_we;

    // On contention the port that did not win last time gets the slot.
    always_comb begin
        w_any_req    = m0_req | m1_req;
        w_winner     = m1_req & (~m0_req | ~r_last_grant);
        w_win_addr   = w_winner ? m1_address      : m0_address;
        w_win_wdata  = w_winner ? m1_write_data   : m0_write_data;
        w_win_we     = w_winner ? m1_write_enable : m0_write_enable;
        w_accept     = (r_state == c_IDLE) & w_any_req & ~reset;
        w_start_wait = w_accept & ~w_win_we & ~c_ZERO_LAT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_count      <= '0;
            r_addr       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_last_grant <= w_winner;
            end
            if (w_start_wait) begin
                r_owner <= w_winner;
                r_addr  <= w_win_addr;
                r_count <= c_LOAD;
            end else if ((r_state == c_WAIT) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_start_wait) w_next_state = c_WAIT;
            c_WAIT:  if (r_count == '0) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Everything is forced quiet while reset is high, which also drops an
    // in-flight read's rvalid.
    always_comb begin
        m0_gnt               = 1'b0;
        m1_gnt               = 1'b0;
        m0_rvalid            = 1'b0;
        m1_rvalid            = 1'b0;
        busy                 = 1'b0;
        memory__address      = '0;
        memory__write_data   = '0;
        memory__write_enable = 1'b0;
        if (!reset) begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        m0_gnt               = ~w_winner;
                        m1_gnt               = w_winner;
                        memory__address      = w_win_addr;
                        memory__write_data   = w_win_wdata;
                        memory__write_enable = w_win_we;
                        if (c_ZERO_LAT && !w_win_we) begin
                            m0_rvalid = ~w_winner;
                            m1_rvalid = w_winner;
                        end
                    end
                end
                c_WAIT: begin
                    busy            = 1'b1;
                    memory__address = r_addr;
                    if (r_count == '0) begin
                        m0_rvalid = ~r_owner;
                        m1_rvalid = r_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_read_data = memory__read_data;
    assign m1_read_data = memory__read_data;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Purpose  : Randomized scoreboard bench for memory_arbiter at read
//            latencies 0, 1 and 3 with a behavioural arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int NCYC = 1500;
    localparam int NTOT = NCYC + 10;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]       m0_req, m1_req, m0_we, m1_we;
    logic [2:0][31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [2:0]       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_we;
    logic [2:0][31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0]      dmem [3][256];

    function automatic int lat_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [31:0] init_word(int k, int i);
        return 32'h5A00_0000 ^ (32'(k) << 20) ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Memory seen by each DUT: asynchronous read, write on the clock edge.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 256; i++)
                    dmem[k][i] <= init_word(k, i);
        end else begin
            for (int k = 0; k < 3; k++)
                if (mem_we[k] === 1'b1) dmem[k][mem_addr[k][7:0]] <= mem_wdata[k];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        assign mem_rdata[g] = dmem[g][mem_addr[g][7:0]];
        memory_arbiter #(.READ_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
            .clk                  (clk),
            .reset                (rst),
            .m0_req               (m0_req[g]),
            .m0_address           (m0_addr[g]),
            .m0_write_data        (m0_wdata[g]),
            .m0_write_enable      (m0_we[g]),
            .m0_gnt               (m0_gnt[g]),
            .m0_rvalid            (m0_rvalid[g]),
            .m0_read_data         (m0_rdata[g]),
            .m1_req               (m1_req[g]),
            .m1_address           (m1_addr[g]),
            .m1_write_data        (m1_wdata[g]),
            .m1_write_enable      (m1_we[g]),
            .m1_gnt               (m1_gnt[g]),
            .m1_rvalid            (m1_rvalid[g]),
            .m1_read_data         (m1_rdata[g]),
            .busy                 (busy[g]),
            .memory__address      (mem_addr[g]),
            .memory__write_data   (mem_wdata[g]),
            .memory__write_enable (mem_we[g]),
            .memory__read_data    (mem_rdata[g])
        );
    end

    typedef struct { int k; int t; bit p; logic [31:0] a; logic [31:0] d; bit we; } gexp_t;
    typedef struct { int k; int t; bit p; logic [31:0] d; } rexp_t;

    gexp_t       gq[$];
    rexp_t       rq[$];
    bit          exp_busy  [3][0:NTOT+4];
    logic [31:0] exp_haddr [3][0:NTOT+4];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(string name, int k, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s lat=%0d cycle=%0d: got %h, expected %h",
                     name, lat_of(k), cyc, got, want);
        end
    endtask

    // Stimulus plus reference model: predicts every grant and read return.
    initial begin : driver
        logic [31:0] refm [3][256];
        bit          act  [3][2];
        bit          rw   [3][2];
        logic [31:0] ra   [3][2];
        logic [31:0] rd   [3][2];
        logic [31:0] hold_a [3];
        bit          last [3];
        int          busy_until [3];
        int          t;
        bit          w;

        rst = 1'b1;
        m0_req = '0; m1_req = '0; m0_we = '0; m1_we = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            last[k] = 1'b1;
            busy_until[k] = -1;
            hold_a[k] = '0;
            for (int i = 0; i < 256; i++) refm[k][i] = init_word(k, i);
            for (int p = 0; p < 2; p++) begin
                act[k][p] = 1'b0; rw[k][p] = 1'b0; ra[k][p] = '0; rd[k][p] = '0;
            end
        end

        for (int it = 0; it < NTOT; it++) begin
            @(posedge clk);
            #1;
            t = cyc;
            if (t <= 3)                       rst = 1'b1;
            else if (t >= 12 && t < NCYC)     rst = ($urandom_range(0, 59) == 0);
            else                              rst = 1'b0;

            for (int k = 0; k < 3; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (t >= NCYC) begin
                        act[k][p] = 1'b0;
                    end else if (!act[k][p]) begin
                        // Reset and the first 8 free cycles: both ports stream writes.
                        if (t < 12) begin
                            act[k][p] = 1'b1;
                            rw[k][p]  = 1'b1;
                            ra[k][p]  = 32'hC0DE_0000 + 32'(t * 8 + p * 4);
                            rd[k][p]  = $urandom;
                        end else if ($urandom_range(0, 2) == 0) begin
                            act[k][p] = 1'b1;
                            rw[k][p]  = ($urandom_range(0, 1) == 1);
                            ra[k][p]  = $urandom;
                            rd[k][p]  = $urandom;
                        end
                    end else if (t >= 12 && $urandom_range(0, 19) == 0) begin
                        act[k][p] = 1'b0;
                    end
                end
                m0_req[k] = act[k][0]; m0_addr[k] = ra[k][0];
                m0_wdata[k] = rd[k][0]; m0_we[k] = rw[k][0];
                m1_req[k] = act[k][1]; m1_addr[k] = ra[k][1];
                m1_wdata[k] = rd[k][1]; m1_we[k] = rw[k][1];

                exp_busy[k][t]  = 1'b0;
                exp_haddr[k][t] = '0;
                if (rst) begin
                    last[k] = 1'b1;
                    busy_until[k] = -1;
                    for (int i = rq.size() - 1; i >= 0; i--)
                        if (rq[i].k == k) rq.delete(i);
                end else if (t <= busy_until[k]) begin
                    exp_busy[k][t]  = 1'b1;
                    exp_haddr[k][t] = hold_a[k];
                end else if (act[k][0] || act[k][1]) begin
                    if (act[k][0] && act[k][1]) w = ~last[k];
                    else                        w = act[k][1];
                    last[k] = w;
                    gq.push_back('{k, t, w, ra[k][w], rd[k][w], rw[k][w]});
                    if (rw[k][w]) begin
                        refm[k][ra[k][w][7:0]] = rd[k][w];
                    end else begin
                        rq.push_back('{k, t + lat_of(k), w, refm[k][ra[k][w][7:0]]});
                        if (lat_of(k) > 0) begin
                            busy_until[k] = t + lat_of(k);
                            hold_a[k]     = ra[k][w];
                        end
                    end
                    act[k][w] = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        int         t;
        int         gi;
        int         ri;
        logic [1:0] g;
        logic [1:0] r;

        repeat (NTOT) begin
            @(negedge clk);
            t = cyc;
            for (int k = 0; k < 3; k++) begin
                g = {m1_gnt[k], m0_gnt[k]};
                r = {m1_rvalid[k], m0_rvalid[k]};
                chk("single_gnt", k, 32'(g == 2'b11), 32'd0);
                chk("single_rvalid", k, 32'(r == 2'b11), 32'd0);
                chk("busy", k, 32'(busy[k]), 32'(exp_busy[k][t]));

                gi = -1;
                foreach (gq[i]) if (gi < 0 && gq[i].k == k) gi = i;
                if (g != 2'b00) begin
                    if (gi < 0) begin
                        chk("gnt_unexpected", k, 32'(g), 32'd0);
                    end else begin
                        chk("gnt_cycle", k, 32'(t), 32'(gq[gi].t));
                        chk("gnt_port", k, 32'(g[1]), 32'(gq[gi].p));
                        chk("mem_addr", k, mem_addr[k], gq[gi].a);
                        chk("mem_we", k, 32'(mem_we[k]), 32'(gq[gi].we));
                        if (gq[gi].we) chk("mem_wdata", k, mem_wdata[k], gq[gi].d);
                        gq.delete(gi);
                    end
                end else begin
                    if (gi >= 0 && gq[gi].t <= t) begin
                        chk("gnt_missing", k, 32'(g), gq[gi].p ? 32'd2 : 32'd1);
                        gq.delete(gi);
                    end
                    chk("mem_we_idle", k, 32'(mem_we[k]), 32'd0);
                    if (exp_busy[k][t]) chk("mem_addr_hold", k, mem_addr[k], exp_haddr[k][t]);
                    else                chk("mem_addr_idle", k, mem_addr[k], 32'd0);
                end

                ri = -1;
                foreach (rq[i]) if (ri < 0 && rq[i].k == k) ri = i;
                if (r != 2'b00) begin
                    if (ri < 0) begin
                        chk("rvalid_unexpected", k, 32'(r), 32'd0);
                    end else begin
                        chk("rvalid_cycle", k, 32'(t), 32'(rq[ri].t));
                        chk("rvalid_port", k, 32'(r[1]), 32'(rq[ri].p));
                        chk("read_data", k, r[1] ? m1_rdata[k] : m0_rdata[k], rq[ri].d);
                        rq.delete(ri);
                    end
                end else if (ri >= 0 && rq[ri].t <= t) begin
                    chk("rvalid_missing", k, 32'(r), rq[ri].p ? 32'd2 : 32'd1);
                    rq.delete(ri);
                end
            end
        end

        chk("pending_gnt", 0, 32'(gq.size()), 32'd0);
        chk("pending_rvalid", 0, 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
